ircam_frame_decoder: RTL and testbench

Parametrised successor to the IR camera UART frame parser. It consumes the received byte stream, finds the frame header and assembles little-endian raw pixels. Each pixel is scaled to OUT_W bits against a range taken from the previous frame, and the block flags frame boundaries and framing errors. It sits between UART_RX and the display/pixel sink, running on the UART sample clock.

---
 rtl/ircam_frame_decoder.sv | 167 ++++++++++++++++
 tb/tb_ircam_frame_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ircam_frame_decoder.sv
// ircam_frame_decoder: IR camera byte-stream frame parser with per-frame range scaling (optional AUTO_FLOOR_EN adaptive floor)
module ircam_frame_decoder #(
   parameter logic [7:0] HDR_BYTE   = 8'h5A,
   parameter int         HDR_LEN    = 2,
   parameter int         SKIP_BYTES = 2,
   parameter int         NUM_PIXELS = 768,
   parameter int         PIX_W      = 16,
   parameter int         OUT_W      = 8,
   parameter int         FLOOR      = 2700,
   parameter int         CEIL_MIN   = 3300,
   parameter int         CLIP_MAX   = 3900
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             pix_valid,
   output logic [OUT_W-1:0] pix_data,
   output logic [PIX_W-1:0] pix_raw,
   output logic             pix_first,
   output logic             pix_last,
   output logic             frame_done,
   output logic             frame_err,
   output logic [PIX_W-1:0] frame_max,
   output logic [PIX_W-1:0] range_ceil
);
   localparam logic [1:0] HUNT = 2'd0, SKIP = 2'd1, LO = 2'd2, HI = 2'd3;
   localparam int IW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int MW = PIX_W + OUT_W;
   localparam logic [PIX_W-1:0] FLOOR_V    = PIX_W'(FLOOR);
   localparam logic [PIX_W-1:0] CEIL_MIN_V = PIX_W'(CEIL_MIN);
   localparam logic [PIX_W-1:0] CLIP_V     = PIX_W'(CLIP_MAX);
   localparam logic [IW-1:0]    LAST_IDX   = IW'(NUM_PIXELS - 1);
   localparam logic [2:0]       HDR_LAST   = 3'(HDR_LEN - 1);
   localparam logic [15:0]      SKIP_LAST  = 16'(SKIP_BYTES - 1);
   localparam logic [OUT_W-1:0] ONES       = '1;

   logic [1:0]       state;
   logic [2:0]       hdr_cnt;
   logic [15:0]      skip_cnt, idle_cnt;
   logic [7:0]       low;
   logic [IW-1:0]    pix_idx;
   logic [PIX_W-1:0] run_max, last_max, raw, max_nxt, ceil_nxt, floor_q;
   logic             s1_valid, s1_first, s1_last;
   logic [PIX_W-1:0] s1_raw;
   logic             hdr_done, pix_in, timeout;
   logic [MW-1:0]    num, den;
   logic [OUT_W-1:0] scaled;

   assign raw      = PIX_W'({in_data, low});
   assign hdr_done = in_valid && state == HUNT && in_data == HDR_BYTE && hdr_cnt == HDR_LAST;
   assign pix_in   = in_valid && state == HI;
   assign timeout  = !in_valid && state != HUNT && idle_cnt == 16'hFFFF;
   assign max_nxt  = (raw > run_max && raw < CLIP_V) ? raw : run_max;
   // last_max is the final max of the last completed frame, available before frame_max catches up
   assign ceil_nxt = (last_max > CEIL_MIN_V) ? last_max : CEIL_MIN_V;

`ifdef AUTO_FLOOR_EN
   logic [PIX_W-1:0] run_min, last_min, min_nxt, floor_cand, floor_nxt;
   assign min_nxt    = (raw != '0 && raw < run_min) ? raw : run_min;
   assign floor_cand = (last_min < FLOOR_V) ? last_min : FLOOR_V;
   assign floor_nxt  = (floor_cand >= ceil_nxt) ? ceil_nxt - PIX_W'(1) : floor_cand;
   // Track the non-zero min per frame and pick the floor at header completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_min  <= '1;
         last_min <= '1;
         floor_q  <= FLOOR_V;
      end else if (!timeout && hdr_done) begin
         run_min <= '1;
         floor_q <= floor_nxt;
      end else if (!timeout && pix_in) begin
         run_min <= min_nxt;
         if (pix_idx == LAST_IDX) last_min <= min_nxt;
      end
   end
`else
   assign floor_q = FLOOR_V;
`endif

   // Header hunt, skip, pixel assembly and idle-timeout abort; also the first pipe stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         hdr_cnt    <= '0;
         skip_cnt   <= '0;
         idle_cnt   <= '0;
         low        <= '0;
         pix_idx    <= '0;
         run_max    <= '0;
         last_max   <= '0;
         range_ceil <= CEIL_MIN_V;
         frame_err  <= 1'b0;
         s1_valid   <= 1'b0;
         s1_raw     <= '0;
         s1_first   <= 1'b0;
         s1_last    <= 1'b0;
      end else begin
         frame_err <= timeout;
         s1_valid  <= pix_in;
         s1_raw    <= raw;
         s1_first  <= pix_idx == '0;
         s1_last   <= pix_idx == LAST_IDX;
         idle_cnt  <= (in_valid || state == HUNT || timeout) ? 16'd0 : idle_cnt + 16'd1;
         if (timeout) begin
            state   <= HUNT;
            hdr_cnt <= '0;
            pix_idx <= '0;
         end else if (in_valid) begin
            case (state)
               HUNT: begin
                  hdr_cnt <= (in_data == HDR_BYTE && !hdr_done) ? hdr_cnt + 3'd1 : 3'd0;
                  if (hdr_done) begin
                     state      <= (SKIP_BYTES == 0) ? LO : SKIP;
                     skip_cnt   <= '0;
                     pix_idx    <= '0;
                     run_max    <= '0;
                     range_ceil <= ceil_nxt;
                  end
               end
               SKIP: begin
                  skip_cnt <= skip_cnt + 16'd1;
                  if (skip_cnt == SKIP_LAST) state <= LO;
               end
               LO: begin
                  low   <= in_data;
                  state <= HI;
               end
               default: begin
                  run_max <= max_nxt;
                  pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + IW'(1);
                  state   <= (pix_idx == LAST_IDX) ? HUNT : LO;
                  if (pix_idx == LAST_IDX) last_max <= max_nxt;
               end
            endcase
         end
      end
   end

   // Scale against [floor, ceil); denominator forced non-zero so a bad range never divides by zero
   always_comb begin
      num    = MW'(s1_raw - floor_q) * MW'(ONES);
      den    = (range_ceil > floor_q) ? MW'(range_ceil - floor_q) : MW'(1);
      scaled = (s1_raw <= floor_q) ? '0 : (s1_raw >= range_ceil) ? ONES : OUT_W'(num / den);
   end

   // Second pipe stage drives the pixel outputs; frame_done and frame_max follow the last pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_valid  <= 1'b0;
         pix_data   <= '0;
         pix_raw    <= '0;
         pix_first  <= 1'b0;
         pix_last   <= 1'b0;
         frame_done <= 1'b0;
         frame_max  <= '0;
      end else begin
         pix_valid  <= s1_valid;
         pix_data   <= s1_valid ? scaled : '0;
         pix_raw    <= s1_valid ? s1_raw : '0;
         pix_first  <= s1_valid && s1_first;
         pix_last   <= s1_valid && s1_last;
         frame_done <= pix_valid && pix_last;
         if (pix_valid && pix_last) frame_max <= last_max;
      end
   end
endmodule

// File: tb/tb_ircam_frame_decoder.sv
// tb_ircam_frame_decoder: directed frame vectors with hand-computed scaling results
module tb_ircam_frame_decoder;
   localparam int NP = 768;
   localparam int MAXP = 8192;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        pix_valid, pix_first, pix_last, frame_done, frame_err;
   logic [7:0]  pix_data;
   logic [15:0] pix_raw, frame_max, range_ceil;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int mon_n = 0, n_first = 0, n_last = 0, n_done = 0, n_err = 0;
   int first_pos = -1, last_pos = -1, done_cyc = 0, err_cyc = 0;
   int mon_data [MAXP];
   int mon_raw [MAXP];
   int pix_cyc [MAXP];
   int b_n, b_first, b_last, b_done, b_err, hi_cyc, end_cyc;

   ircam_frame_decoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_raw(pix_raw),
      .pix_first(pix_first), .pix_last(pix_last), .frame_done(frame_done),
      .frame_err(frame_err), .frame_max(frame_max), .range_ceil(range_ceil)
   );

   always #5 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (pix_valid) begin
         if (mon_n < MAXP) begin
            mon_data[mon_n] = pix_data;
            mon_raw[mon_n] = pix_raw;
            pix_cyc[mon_n] = cyc;
         end
         if (pix_first) begin n_first++; first_pos = mon_n; end
         if (pix_last) begin n_last++; last_pos = mon_n; end
         mon_n++;
      end
      if (frame_done) begin n_done++; done_cyc = cyc; end
      if (frame_err) begin n_err++; err_cyc = cyc; end
   end

   // Watchdog
   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: run did not end within 95000 cycles");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_hdr();
      send_byte(8'h5A); send_byte(8'h5A); send_byte(8'h00); send_byte(8'h06);
   endtask

   function automatic logic [15:0] pv(input int kind, input int i);
      case (kind)
         1:       pv = (i == 0) ? 16'd3600 : (i == 1) ? 16'd3150 : (i == 2) ? 16'd2700 : 16'd3000;
         3:       pv = (i == 0) ? 16'd3400 : (i == 5) ? 16'd3950 : 16'd3000;
         4:       pv = 16'd3200;
         default: pv = 16'd3000;
      endcase
   endfunction

   task automatic send_pixels(input int kind, input int n);
      logic [15:0] v;
      for (int i = 0; i < n; i++) begin
         v = pv(kind, i);
         send_byte(v[7:0]);
         send_byte(v[15:8]);
         if (i == 0) hi_cyc = cyc;
      end
      end_cyc = cyc;
   endtask

   task automatic snap();
      b_n = mon_n; b_first = n_first; b_last = n_last; b_done = n_done; b_err = n_err;
   endtask

   task automatic send_frame(input int kind);
      snap();
      send_hdr();
      send_pixels(kind, NP);
      idle(6);
   endtask

   task automatic chk_frame(input string tag, input int ceil_exp, input int max_exp);
      chk({tag, " count"}, mon_n - b_n, NP);
      chk({tag, " first"}, n_first - b_first, 1);
      chk({tag, " last"}, n_last - b_last, 1);
      chk({tag, " done"}, n_done - b_done, 1);
      chk({tag, " ceil"}, range_ceil, ceil_exp);
      chk({tag, " max"}, frame_max, max_exp);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset pix_valid", pix_valid, 0);
      chk("reset range_ceil", range_ceil, 3300);
      chk("reset frame_max", frame_max, 0);
      chk("reset frame_done", frame_done, 0);
      chk("reset frame_err", frame_err, 0);
      rst = 1'b0;
      idle(2);

      send_frame(0);
      chk_frame("f0", 3300, 3000);
      chk("f0 data0", mon_data[b_n], 127);
      chk("f0 data767", mon_data[b_n + NP - 1], 127);
      chk("f0 raw0", mon_raw[b_n], 3000);
      chk("f0 first pos", first_pos, b_n);
      chk("f0 last pos", last_pos, b_n + NP - 1);
      chk("f0 latency", pix_cyc[b_n] - hi_cyc, 2);
      chk("f0 done delay", done_cyc - pix_cyc[b_n + NP - 1], 1);

      send_frame(1);
      chk_frame("f1", 3300, 3600);
      chk("f1 data 3600", mon_data[b_n], 255);
      chk("f1 data 3150", mon_data[b_n + 1], 191);
      chk("f1 data 2700", mon_data[b_n + 2], 0);

      send_frame(1);
      chk_frame("f2", 3600, 3600);
      chk("f2 data 3600", mon_data[b_n], 255);
      chk("f2 data 3150", mon_data[b_n + 1], 127);
      chk("f2 data 2700", mon_data[b_n + 2], 0);
      chk("f2 data 3000", mon_data[b_n + 3], 85);

      send_frame(3);
      chk_frame("f3 clip", 3600, 3400);
      chk("f3 data 3400", mon_data[b_n], 198);
      chk("f3 data 3950", mon_data[b_n + 5], 255);
      chk("f3 raw 3950", mon_raw[b_n + 5], 3950);

      snap();
      send_byte(8'h5A); send_byte(8'h11);
      idle(4);
      chk("hdr no early pix", mon_n - b_n, 0);
      send_hdr();
      send_pixels(0, NP);
      idle(6);
      chk_frame("hdr", 3400, 3000);
      chk("hdr raw0", mon_raw[b_n], 3000);
      chk("hdr raw767", mon_raw[b_n + NP - 1], 3000);
      chk("hdr data0", mon_data[b_n], 109);

      snap();
      send_hdr();
      send_pixels(4, 10);
      idle(70000);
      chk("tmo err count", n_err - b_err, 1);
      chk("tmo err time", err_cyc - end_cyc, 65537);
      chk("tmo pix count", mon_n - b_n, 10);
      chk("tmo no last", n_last - b_last, 0);
      chk("tmo no done", n_done - b_done, 0);
      chk("tmo frame_max", frame_max, 3000);
      chk("tmo ceil", range_ceil, 3300);

      send_frame(0);
      chk_frame("post tmo", 3300, 3000);
      chk("post tmo data0", mon_data[b_n], 127);

      send_frame(1);
      chk("pre rst max", frame_max, 3600);
      snap();
      send_hdr();
      send_pixels(0, 100);
      send_byte(8'hB8);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst pix_valid", pix_valid, 0);
      chk("rst range_ceil", range_ceil, 3300);
      chk("rst frame_max", frame_max, 0);
      chk("rst frame_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b0;
      b_n = mon_n;
      send_pixels(0, 30);
      idle(6);
      chk("rst no pix", mon_n - b_n, 0);
      send_frame(0);
      chk_frame("post rst", 3300, 3000);
      chk("post rst data0", mon_data[b_n], 127);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
